avalon_bus_matrix_burst_arbiter: RTL and testbench

- Sequential, burst-aware arbiter for one slave port of the Avalon bus matrix; shares the slave between NUM_MASTERS master ports.
- Picks a winner with round-robin or fixed priority, then holds the grant until the whole transaction is done: all write beats accepted, or all read beats returned.
- Produces the port-select index, no-select flag and one-hot grant that drive the matrix address/data muxes and readdata demux.

---
 rtl/avalon_bus_matrix_pkg.sv | 25 ++
 rtl/avalon_bus_matrix_burst_arbiter_if.sv | 28 ++
 rtl/avalon_bus_matrix_rr_pick.sv | 27 ++
 rtl/avalon_bus_matrix_burst_arbiter.sv | 136 +++++++++++++
 tb/tb_avalon_bus_matrix_burst_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_bus_matrix_pkg.sv
// Shared types and helpers for the Avalon bus-matrix burst arbiter.
package avalon_bus_matrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ_CMD,
    ST_READ_DATA
  } arb_state_e;

  localparam int unsigned DEF_NUM_MASTERS = 5;
  localparam int unsigned SEL_W           = $clog2(DEF_NUM_MASTERS);
  localparam int unsigned MAX_BURST_W     = 8;
  localparam int unsigned BC_VEC_W        = 64;

  // Extract master idx's burstcount field from a packed per-master vector.
  function automatic logic [MAX_BURST_W-1:0] bc_slice(input logic [BC_VEC_W-1:0] vec,
                                                      input int unsigned idx,
                                                      input int unsigned bw);
    logic [BC_VEC_W-1:0] mask;
    mask = (BC_VEC_W'(1) << bw) - BC_VEC_W'(1);
    return MAX_BURST_W'((vec >> (idx * bw)) & mask);
  endfunction

endpackage

// File: rtl/avalon_bus_matrix_burst_arbiter_if.sv
// Request/response bundle between the matrix master ports and one slave-port arbiter.
interface avalon_bus_matrix_burst_arbiter_if #(
  parameter int unsigned NUM_MASTERS = avalon_bus_matrix_pkg::DEF_NUM_MASTERS,
  parameter int unsigned BURST_W     = 4
);
  localparam int unsigned PSEL_W = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0]         read_i;
  logic [NUM_MASTERS-1:0]         write_i;
  logic [NUM_MASTERS*BURST_W-1:0] burstcount_i;
  logic                           slv_waitrequest_i;
  logic                           slv_readdatavalid_i;
  logic [PSEL_W-1:0]              port_sel_o;
  logic                           port_no_sel_o;
  logic [NUM_MASTERS-1:0]         grant_o;
  logic                           busy_o;
  logic                           err_o;

  modport master (
    output read_i, write_i, burstcount_i, slv_waitrequest_i, slv_readdatavalid_i,
    input  port_sel_o, port_no_sel_o, grant_o, busy_o, err_o
  );

  modport slave (
    input  read_i, write_i, burstcount_i, slv_waitrequest_i, slv_readdatavalid_i,
    output port_sel_o, port_no_sel_o, grant_o, busy_o, err_o
  );
endinterface

// File: rtl/avalon_bus_matrix_rr_pick.sv
// Combinational picker: rotating priority from last+1, or fixed priority with port 0 highest.
module avalon_bus_matrix_rr_pick #(
  parameter int unsigned NUM_MASTERS = 5,
  parameter int unsigned ROUND_ROBIN = 1,
  localparam int unsigned SEL_W      = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [SEL_W-1:0]       i_last,
  output logic [SEL_W-1:0]       o_winner,
  output logic                   o_any
);

  always_comb begin
    int unsigned idx;
    idx      = 0;
    o_winner = '0;
    o_any    = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      idx = (ROUND_ROBIN != 0) ? (32'(i_last) + i + 1) % NUM_MASTERS : i;
      if (!o_any && i_req[SEL_W'(idx)]) begin
        o_any    = 1'b1;
        o_winner = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/avalon_bus_matrix_burst_arbiter.sv
// Burst-aware slave-port arbiter: grants one master and holds it until every beat is done.
module avalon_bus_matrix_burst_arbiter
  import avalon_bus_matrix_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int unsigned BURST_W     = 4,
  parameter int unsigned ROUND_ROBIN = 1
) (
  input logic clk,
  input logic rst,
  avalon_bus_matrix_burst_arbiter_if.slave bus
);

  localparam int unsigned PSEL_W = $clog2(NUM_MASTERS);

  arb_state_e               r_state;
  logic [NUM_MASTERS-1:0]   r_grant;
  logic [PSEL_W-1:0]        r_port_sel;
  logic                     r_no_sel;
  logic                     r_busy;
  logic                     r_err;
  logic [BURST_W-1:0]       r_cnt;
  logic [BURST_W-1:0]       r_bc;
  logic [PSEL_W-1:0]        r_last;

  logic [NUM_MASTERS-1:0]   w_req;
  logic [PSEL_W-1:0]        w_winner;
  logic                     w_any;
  logic [BURST_W-1:0]       w_bc_raw;
  logic [BURST_W-1:0]       w_bc;
  logic                     w_beat_wr;
  logic                     w_cmd_rd;

  assign w_req = bus.read_i | bus.write_i;

  avalon_bus_matrix_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_pick (
    .i_req    (w_req),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // A zero burstcount still moves one beat.
  assign w_bc_raw  = BURST_W'(bc_slice(BC_VEC_W'(bus.burstcount_i), 32'(w_winner), BURST_W));
  assign w_bc      = (w_bc_raw == '0) ? BURST_W'(1) : w_bc_raw;
  assign w_beat_wr = bus.write_i[r_port_sel] & ~bus.slv_waitrequest_i;
  assign w_cmd_rd  = bus.read_i[r_port_sel] & ~bus.slv_waitrequest_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_port_sel <= '0;
      r_no_sel   <= 1'b1;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
      r_bc       <= '0;
      r_last     <= PSEL_W'(NUM_MASTERS - 1);
    end else begin
      // Read data with no read outstanding is a protocol violation.
      if (bus.slv_readdatavalid_i && (r_state != ST_READ_DATA))
        r_err <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant    <= NUM_MASTERS'(1) << w_winner;
            r_port_sel <= w_winner;
            r_no_sel   <= 1'b0;
            r_busy     <= 1'b1;
            r_bc       <= w_bc;
            r_cnt      <= w_bc;
            if (bus.write_i[w_winner]) begin
              r_state <= ST_WRITE;
              if (bus.read_i[w_winner])
                r_err <= 1'b1;
            end else begin
              r_state <= ST_READ_CMD;
            end
          end
        end

        ST_WRITE: begin
          if (w_beat_wr) begin
            if (r_cnt == BURST_W'(1)) begin
              r_state  <= ST_IDLE;
              r_grant  <= '0;
              r_no_sel <= 1'b1;
              r_busy   <= 1'b0;
              r_cnt    <= '0;
              r_last   <= r_port_sel;
            end else begin
              r_cnt <= r_cnt - BURST_W'(1);
            end
          end
        end

        ST_READ_CMD: begin
          if (w_cmd_rd) begin
            r_cnt   <= r_bc;
            r_state <= ST_READ_DATA;
          end
        end

        ST_READ_DATA: begin
          // Grant held so port_sel keeps steering readdata to the owner.
          if (bus.slv_readdatavalid_i) begin
            if (r_cnt == BURST_W'(1)) begin
              r_state  <= ST_IDLE;
              r_grant  <= '0;
              r_no_sel <= 1'b1;
              r_busy   <= 1'b0;
              r_cnt    <= '0;
              r_last   <= r_port_sel;
            end else begin
              r_cnt <= r_cnt - BURST_W'(1);
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant_o       = r_grant;
  assign bus.port_sel_o    = r_port_sel;
  assign bus.port_no_sel_o = r_no_sel;
  assign bus.busy_o        = r_busy;
  assign bus.err_o         = r_err;

endmodule

// File: tb/tb_avalon_bus_matrix_burst_arbiter.sv
// Randomized and directed bench for the burst arbiter against a transaction-level model.
module tb_avalon_bus_matrix_burst_arbiter;
  import avalon_bus_matrix_pkg::*;

  localparam int unsigned N  = 5;
  localparam int unsigned BW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  avalon_bus_matrix_burst_arbiter_if #(.NUM_MASTERS(N), .BURST_W(BW)) bus ();
  avalon_bus_matrix_burst_arbiter_if #(.NUM_MASTERS(N), .BURST_W(BW)) bus_fp ();

  assign bus_fp.read_i              = bus.read_i;
  assign bus_fp.write_i             = bus.write_i;
  assign bus_fp.burstcount_i        = bus.burstcount_i;
  assign bus_fp.slv_waitrequest_i   = bus.slv_waitrequest_i;
  assign bus_fp.slv_readdatavalid_i = bus.slv_readdatavalid_i;

  avalon_bus_matrix_burst_arbiter #(.NUM_MASTERS(N), .BURST_W(BW), .ROUND_ROBIN(1))
    u_dut (.clk(clk), .rst(rst), .bus(bus));
  avalon_bus_matrix_burst_arbiter #(.NUM_MASTERS(N), .BURST_W(BW), .ROUND_ROBIN(0))
    u_dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: owner of the slave, beats left, phase 0=write 1=read cmd 2=read data.
  int m_owner = -1;
  int m_phase = 0;
  int m_left  = 0;
  int m_bc    = 0;
  int m_last  = N - 1;
  int m_err   = 0;
  int m_done  = -1;

  function automatic int bc_of(int m);
    logic [N*BW-1:0] t;
    t = bus.burstcount_i >> (m * BW);
    return (t[BW-1:0] == '0) ? 1 : int'(t[BW-1:0]);
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_phase = 0; m_left = 0; m_last = N - 1; m_err = 0; m_done = -1;
  endfunction

  function automatic void model_release();
    m_last  = m_owner;
    m_done  = m_owner;
    m_owner = -1;
  endfunction

  function automatic void model_step();
    logic [N-1:0] req;
    m_done = -1;
    req = bus.read_i | bus.write_i;
    if (bus.slv_readdatavalid_i && !(m_owner >= 0 && m_phase == 2)) m_err = 1;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (m_owner < 0 && req[c]) begin
          m_owner = c;
          m_bc    = bc_of(c);
          m_left  = m_bc;
          m_phase = bus.write_i[c] ? 0 : 1;
          if (bus.write_i[c] && bus.read_i[c]) m_err = 1;
        end
      end
    end else if (m_phase == 0) begin
      if (bus.write_i[m_owner] && !bus.slv_waitrequest_i) begin
        m_left--;
        if (m_left == 0) model_release();
      end
    end else if (m_phase == 1) begin
      if (bus.read_i[m_owner] && !bus.slv_waitrequest_i) begin
        m_phase = 2;
        m_left  = m_bc;
      end
    end else if (bus.slv_readdatavalid_i) begin
      m_left--;
      if (m_left == 0) model_release();
    end
  endfunction

  // Expected {grant, port_sel, no_sel, busy, err}; port_sel only meaningful while granted.
  function automatic logic [10:0] exp_vec();
    logic [4:0] g;
    logic [2:0] s;
    g = (m_owner < 0) ? 5'b0 : 5'(5'b1 << m_owner);
    s = (m_owner < 0) ? 3'b0 : 3'(m_owner);
    return {g, s, (m_owner < 0), (m_owner >= 0), (m_err != 0)};
  endfunction

  function automatic logic [10:0] act_vec();
    return {bus.grant_o, (bus.port_no_sel_o ? 3'b0 : bus.port_sel_o),
            bus.port_no_sel_o, bus.busy_o, bus.err_o};
  endfunction

  task automatic tick();
    if (rst) model_reset(); else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_done();
    if (m_done >= 0) begin
      bus.read_i[m_done]  = 1'b0;
      bus.write_i[m_done] = 1'b0;
    end
    if (m_owner >= 0 && m_phase == 2) bus.read_i[m_owner] = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.read_i = '0; bus.write_i = '0; bus.burstcount_i = '0;
    bus.slv_waitrequest_i = 1'b0; bus.slv_readdatavalid_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (act_vec() !== 11'b00000_000_1_0_0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want %b", act_vec(), 11'b00000_000_1_0_0);
    end
    n_checks++;
    if (bus.port_sel_o !== 3'd0) begin
      n_fail++; $display("FAIL reset_port_sel: got %0d want 0", bus.port_sel_o);
    end
  endtask

  task automatic test_back_to_back();
    bus.burstcount_i[1*BW +: BW] = 4'd1;
    bus.burstcount_i[2*BW +: BW] = 4'd1;
    bus.write_i = 5'b00110;
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL b2b_model cyc %0d: got %b want %b", c, act_vec(), exp_vec());
      end
      if (c == 1 || c == 2 || c == 3) begin
        logic [7:0] want;
        want = (c == 1) ? {5'b00010, 3'd1} : (c == 2) ? 8'b0 : {5'b00100, 3'd2};
        n_checks++;
        if ({bus.grant_o, bus.port_no_sel_o ? 3'd0 : bus.port_sel_o} !== want) begin
          n_fail++; $display("FAIL b2b_edge%0d: got %b/%0d want %b", c, bus.grant_o, bus.port_sel_o, want);
        end
      end
      drop_done();
    end
  endtask

  task automatic test_burst_hold();
    int ws [7] = '{0, 1, 1, 0, 0, 0, 0};
    logic prev_no_sel;
    logic saw_m0_done;
    logic finished;
    bus.burstcount_i[0*BW +: BW] = 4'd4;
    bus.burstcount_i[3*BW +: BW] = 4'd1;
    bus.write_i[0] = 1'b1;
    tick();
    bus.read_i[3] = 1'b1;
    prev_no_sel = 1'b0; saw_m0_done = 1'b0; finished = 1'b0;
    for (int c = 0; c < 40 && !finished; c++) begin
      bus.slv_waitrequest_i   = (c < 7) ? 1'(ws[c]) : 1'b0;
      bus.slv_readdatavalid_i = (m_owner == 3 && m_phase == 2);
      tick();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL hold_model cyc %0d: got %b want %b", c, act_vec(), exp_vec());
      end
      if (m_done == 0) saw_m0_done = 1'b1;
      if (bus.grant_o == 5'b01000 && m_phase == 1 && m_owner == 3 && !prev_no_sel) begin
        n_checks++;
        if (!saw_m0_done) begin
          n_fail++; $display("FAIL hold_preempt: got grant %b before master0 finished want 00001", bus.grant_o);
        end
      end
      prev_no_sel = bus.port_no_sel_o;
      if (m_done == 3) finished = 1'b1;
      drop_done();
    end
    bus.slv_waitrequest_i = 1'b0; bus.slv_readdatavalid_i = 1'b0;
    n_checks++;
    if (!finished) begin
      n_fail++; $display("FAIL hold_timeout: got unfinished want master3 done");
    end
  endtask

  task automatic test_read_burst();
    int beats;
    logic finished;
    beats = 0; finished = 1'b0;
    bus.burstcount_i[4*BW +: BW] = 4'd8;
    bus.read_i[4] = 1'b1;
    for (int c = 0; c < 60 && !finished; c++) begin
      bus.slv_readdatavalid_i = (m_owner == 4 && m_phase == 2) ? 1'(c % 2) : 1'b0;
      if (bus.slv_readdatavalid_i) beats++;
      tick();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL read_model cyc %0d: got %b want %b", c, act_vec(), exp_vec());
      end
      if (m_owner == 4) begin
        n_checks++;
        if (bus.busy_o !== 1'b1 || bus.port_sel_o !== 3'd4) begin
          n_fail++; $display("FAIL read_steer cyc %0d: got busy %b sel %0d want 1/4", c, bus.busy_o, bus.port_sel_o);
        end
      end
      if (m_done == 4) finished = 1'b1;
      drop_done();
    end
    bus.slv_readdatavalid_i = 1'b0;
    n_checks++;
    if (!finished || beats != 8 || bus.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL read_finish: got beats %0d busy %b want 8/0", beats, bus.busy_o);
    end
  endtask

  task automatic test_round_robin();
    int order [6];
    int n_gr;
    int fp_gr;
    logic [4:0] prev;
    rst = 1'b1; tick(); rst = 1'b0;
    bus.burstcount_i = 20'h11111;
    bus.write_i = 5'b11111;
    n_gr = 0; fp_gr = 0; prev = '0;
    for (int c = 0; c < 18; c++) begin
      tick();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rr_model cyc %0d: got %b want %b", c, act_vec(), exp_vec());
      end
      if (prev == 5'b0 && bus.grant_o != 5'b0 && n_gr < 6) begin
        order[n_gr] = int'(bus.port_sel_o);
        n_gr++;
      end
      prev = bus.grant_o;
      n_checks++;
      if (bus_fp.grant_o !== 5'b0 && bus_fp.grant_o !== 5'b00001) begin
        n_fail++; $display("FAIL fp_grant cyc %0d: got %b want 00000/00001", c, bus_fp.grant_o);
      end
      if (bus_fp.grant_o == 5'b00001) fp_gr++;
    end
    n_checks++;
    if (n_gr != 6 || order[0] != 0 || order[1] != 1 || order[2] != 2 ||
        order[3] != 3 || order[4] != 4 || order[5] != 0) begin
      n_fail++;
      $display("FAIL rr_order: got %0d grants %0d,%0d,%0d,%0d,%0d,%0d want 0,1,2,3,4,0",
               n_gr, order[0], order[1], order[2], order[3], order[4], order[5]);
    end
    n_checks++;
    if (fp_gr == 0) begin
      n_fail++; $display("FAIL fp_never_granted: got 0 grant cycles want >0");
    end
    bus.write_i = (m_owner >= 0) ? 5'(5'b1 << m_owner) : 5'b0;
    for (int c = 0; c < 10 && m_owner >= 0; c++) tick();
    bus.write_i = '0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    int beats;
    beats = 0;
    bus.burstcount_i[2*BW +: BW] = 4'd8;
    bus.read_i[2] = 1'b1;
    for (int c = 0; c < 30 && beats < 2; c++) begin
      bus.slv_readdatavalid_i = (m_owner == 2 && m_phase == 2);
      if (bus.slv_readdatavalid_i) beats++;
      tick();
      drop_done();
    end
    n_checks++;
    if (bus.busy_o !== 1'b1 || bus.grant_o !== 5'b00100) begin
      n_fail++; $display("FAIL midrst_pre: got busy %b grant %b want 1/00100", bus.busy_o, bus.grant_o);
    end
    bus.slv_readdatavalid_i = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.slv_readdatavalid_i = 1'b0;
    bus.read_i = '0;
    n_checks++;
    if ({bus.grant_o, bus.port_no_sel_o, bus.busy_o, bus.err_o} !== 8'b00000_1_0_0) begin
      n_fail++;
      $display("FAIL midrst_post: got grant %b nosel %b busy %b err %b want 00000 1 0 0",
               bus.grant_o, bus.port_no_sel_o, bus.busy_o, bus.err_o);
    end
  endtask

  task automatic test_errors();
    bus.slv_readdatavalid_i = 1'b1;
    tick();
    bus.slv_readdatavalid_i = 1'b0;
    n_checks++;
    if (bus.err_o !== 1'b1 || act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL err_idle_rdv: got %b want %b", act_vec(), exp_vec());
    end
    bus.burstcount_i[1*BW +: BW] = 4'd0;
    bus.write_i[1] = 1'b1;
    tick();
    tick();
    drop_done();
    n_checks++;
    if (bus.busy_o !== 1'b0 || bus.err_o !== 1'b1 || act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL err_bc0_write: got busy %b err %b want 0/1", bus.busy_o, bus.err_o);
    end
    tick();
    n_checks++;
    if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL err_sticky: got err %b busy %b want 1/0", bus.err_o, bus.busy_o);
    end
  endtask

  task automatic test_random();
    rst = 1'b1; tick(); rst = 1'b0;
    idle_inputs();
    for (int c = 0; c < 600; c++) begin
      if (c < 450) begin
        for (int m = 0; m < N; m++) begin
          if (!bus.read_i[m] && !bus.write_i[m] && m != m_owner && $urandom_range(5) == 0) begin
            bus.burstcount_i[m*BW +: BW] = 4'($urandom_range(4));
            if ($urandom_range(1) == 1) bus.write_i[m] = 1'b1; else bus.read_i[m] = 1'b1;
          end
        end
      end
      bus.slv_waitrequest_i   = ($urandom_range(2) == 0);
      bus.slv_readdatavalid_i = (m_owner >= 0 && m_phase == 2) ? 1'($urandom_range(1)) : 1'b0;
      tick();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rand_model cyc %0d: got %b want %b", c, act_vec(), exp_vec());
      end
      drop_done();
    end
    n_checks++;
    if (bus.busy_o !== 1'b0 || (bus.read_i | bus.write_i) !== 5'b0) begin
      n_fail++; $display("FAIL rand_drain: got busy %b req %b want 0/00000", bus.busy_o, bus.read_i | bus.write_i);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_burst_hold();
    test_read_burst();
    test_round_robin();
    test_reset_mid_burst();
    test_errors();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
